// File: rtl/register_file_8x16.sv
`default_nettype none
// ============================================================================
// Module   : register_file_8x16
// Brief    : 8 x WIDTH register file, one synchronous write port and two
//            combinational read ports. Optional macro WRITE_BYPASS_EN
//            forwards same-cycle write data onto a matching read port.
// Revision : 1.0 - initial release
// ============================================================================
module register_file_8x16 #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [2:0]       waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [2:0]       raddr_a,
    input  logic [2:0]       raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [WIDTH-1:0] w_mem_a;
    logic [WIDTH-1:0] w_mem_b;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    // Reset wins over a write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Each output bit is an independent 8-to-1 mux over one bit column.
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [DEPTH-1:0] w_col;
        for (genvar n = 0; n < DEPTH; n++) begin : g_col
            assign w_col[n] = regs_q[n][b];
        end
        assign w_mem_a[b] = w_col[raddr_a];
        assign w_mem_b[b] = w_col[raddr_b];
    end

`ifdef WRITE_BYPASS_EN
    logic w_byp_a;
    logic w_byp_b;

    assign w_byp_a = we && !rst && (raddr_a == waddr);
    assign w_byp_b = we && !rst && (raddr_b == waddr);
    assign rdata_a = w_byp_a ? wdata : w_mem_a;
    assign rdata_b = w_byp_b ? wdata : w_mem_b;
`else
    assign rdata_a = w_mem_a;
    assign rdata_b = w_mem_b;
`endif

endmodule
`default_nettype wire

// File: tb/tb_register_file_8x16.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_file_8x16
// Brief    : Self-checking bench for register_file_8x16 (table vectors plus
//            directed multi-cycle sequences, expected values via a queue).
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_file_8x16;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             we;
    logic [2:0]       waddr;
    logic [WIDTH-1:0] wdata;
    logic [2:0]       raddr_a;
    logic [2:0]       raddr_b;
    logic [WIDTH-1:0] rdata_a;
    logic [WIDTH-1:0] rdata_b;

    register_file_8x16 #(.WIDTH(WIDTH), .DEPTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (raddr_a),
        .raddr_b (raddr_b),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       waddr;
        logic [WIDTH-1:0] wdata;
        logic [2:0]       raddr_a;
        logic [2:0]       raddr_b;
        logic [WIDTH-1:0] exp_a;
        logic [WIDTH-1:0] exp_b;
    } vec_t;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } exp_t;

    exp_t             sbq[$];
    vec_t             tbl[8];
    logic [WIDTH-1:0] model[8];
    int               checks = 0;
    int               errors = 0;

    task automatic compare(input string name, input logic [WIDTH-1:0] act,
                           input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock with the given controls; controls drop back to idle after.
    task automatic cycle(input logic r, input logic w, input logic [2:0] wa,
                         input logic [WIDTH-1:0] wd);
        @(negedge clk);
        rst = r; we = w; waddr = wa; wdata = wd;
        @(posedge clk);
        #1;
        if (r) begin
            for (int i = 0; i < 8; i++) model[i] = '0;
        end else if (w) begin
            model[wa] = wd;
        end
        rst = 1'b0;
        we  = 1'b0;
    endtask

    task automatic pop_check(input logic [WIDTH-1:0] act_a, input logic [WIDTH-1:0] act_b);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sbq.pop_front();
            compare({e.name, "_a"}, act_a, e.a);
            compare({e.name, "_b"}, act_b, e.b);
        end
    endtask

    task automatic rd(input string name, input logic [2:0] ra, input logic [2:0] rb);
        exp_t e;
        @(negedge clk);
        raddr_a = ra;
        raddr_b = rb;
        e.name = name; e.a = model[ra]; e.b = model[rb];
        sbq.push_back(e);
        #1;
        pop_check(rdata_a, rdata_b);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
        for (int i = 0; i < 8; i++) model[i] = 'x;

        // Reset state
        cycle(1'b1, 1'b0, 3'd0, 16'h0);
        for (int i = 0; i < 8; i++) rd("rst_state", 3'(i), 3'(7 - i));

        // Fill with ones, then reset clears everything
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 3'(i), 16'hFFFF);
        rd("all_ones", 3'd0, 3'd7);
        cycle(1'b1, 1'b0, 3'd0, 16'h0);
        for (int i = 0; i < 8; i++) rd("rst_clear", 3'(i), 3'(i));

        // Table-driven write/read sweep
        for (int n = 0; n < 8; n++) begin
            tbl[n].waddr   = 3'(n);
            tbl[n].wdata   = 16'(16'h1111 * n);
            tbl[n].raddr_a = 3'(n);
            tbl[n].raddr_b = 3'(7 - n);
            tbl[n].exp_a   = 16'(16'h1111 * n);
            tbl[n].exp_b   = 16'(16'h1111 * (7 - n));
        end
        for (int n = 0; n < 8; n++) cycle(1'b0, 1'b1, tbl[n].waddr, tbl[n].wdata);
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            raddr_a = tbl[n].raddr_a;
            raddr_b = tbl[n].raddr_b;
            e.name = "sweep"; e.a = tbl[n].exp_a; e.b = tbl[n].exp_b;
            sbq.push_back(e);
            #1;
            pop_check(rdata_a, rdata_b);
        end

        // Reset priority over write; bypass suppressed while rst=1
        @(negedge clk);
        rst = 1'b1; we = 1'b1; waddr = 3'd3; wdata = 16'hBEEF;
        raddr_a = 3'd3; raddr_b = 3'd3;
        #1;
        compare("rst_no_bypass", rdata_a, 16'h3333);
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) model[i] = '0;
        rst = 1'b0; we = 1'b0;
        rd("rst_prio", 3'd3, 3'd3);
        compare("rst_prio_const", rdata_a, 16'h0000);

        // Read during write
        cycle(1'b0, 1'b1, 3'd5, 16'h00AA);
        @(negedge clk);
        we = 1'b1; waddr = 3'd5; wdata = 16'h5555; raddr_a = 3'd5; raddr_b = 3'd4;
        #1;
`ifdef WRITE_BYPASS_EN
        compare("rdw_pre", rdata_a, 16'h5555);
`else
        compare("rdw_pre", rdata_a, 16'h00AA);
`endif
        compare("rdw_other", rdata_b, 16'h0000);
        @(posedge clk);
        #1;
        model[5] = 16'h5555;
        we = 1'b0;
        rd("rdw_post", 3'd5, 3'd5);

        // Reset mid-sequence
        cycle(1'b0, 1'b1, 3'd1, 16'hAAAA);
        cycle(1'b1, 1'b1, 3'd2, 16'hBBBB);
        cycle(1'b0, 1'b1, 3'd6, 16'hCCCC);
        rd("mid_rst", 3'd1, 3'd2);
        rd("mid_rst_after", 3'd6, 3'd5);

        // Hold with toggling data and we=0
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 3'(i), 16'(16'h0101 * (i + 1)));
        for (int k = 0; k < 10; k++) begin
            wdata = k[0] ? 16'hDEAD : 16'h2152;
            rd("hold", 3'(k % 8), 3'(7 - (k % 8)));
        end

        // Back-to-back writes to the same register
        cycle(1'b0, 1'b1, 3'd2, 16'h0001);
        cycle(1'b0, 1'b1, 3'd2, 16'h0002);
        rd("b2b", 3'd2, 3'd1);
        rd("b2b_r3", 3'd3, 3'd2);
        compare("b2b_const", rdata_b, 16'h0002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
